// File: rtl/iir_pole_ctrl_if.sv
// Sample-in / filter-out streams of the IIR pole frame sequencer.
interface iir_pole_ctrl_if #(
  parameter int unsigned WL   = 16,
  parameter int unsigned WL_Y = 36
);
  logic [WL-1:0]   s_data;
  logic            s_valid;
  logic            s_ready;
  logic [WL_Y-1:0] y_data;
  logic            y_valid;
  logic            y_last;

  modport master (output s_data, s_valid, input s_ready, y_data, y_valid, y_last);
  modport slave  (input s_data, s_valid, output s_ready, y_data, y_valid, y_last);
endinterface

// File: rtl/iir_pole_ctrl.sv
// Frame sequencer for the online IIR pole: streams frame_len samples into the
// pole, appends TAIL zero slots to drain its delay line, and registers the
// pole's combinational output into a flagged output stream.
module iir_pole_ctrl #(
  parameter int unsigned STAGE = 8,
  parameter int unsigned WL    = 2*STAGE,
  parameter int unsigned WL_Y  = 2*(STAGE+10),
  parameter int unsigned LEN_W = 16,
  parameter int unsigned TAIL  = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             abort,
  iir_pole_ctrl_if.slave   s,
  output logic             pole_enable,
  output logic [WL-1:0]    pole_din,
  input  logic [WL_Y-1:0]  pole_dout,
  output logic             busy,
  output logic             done,
  output logic             err_underrun
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic            pole_enable_q, pole_enable_d;
  logic [WL-1:0]   pole_din_q, pole_din_d;
  logic            issued_q, issued_d;
  logic            last_slot_q, last_slot_d;
  logic [WL_Y-1:0] y_data_q, y_data_d;
  logic            y_valid_q, y_valid_d;
  logic            y_last_q, y_last_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  // Next-state, slot issue and output capture logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pole_enable_d = pole_enable_q;
    pole_din_d    = pole_din_q;
    issued_d      = 1'b0;
    last_slot_d   = 1'b0;
    y_valid_d     = issued_q;
    y_last_d      = issued_q & last_slot_q;
    y_data_d      = issued_q ? pole_dout : y_data_q;
    done_d        = 1'b0;
    err_d         = err_q;

    if (abort && (state_q != IDLE)) begin
      // Abort drops the slot still in flight: its output strobe is suppressed.
      state_d       = IDLE;
      cnt_d         = '0;
      pole_enable_d = 1'b0;
      pole_din_d    = '0;
      y_valid_d     = 1'b0;
      y_last_d      = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          pole_enable_d = 1'b0;
          pole_din_d    = '0;
          if (start && !abort && (frame_len != '0)) begin
            state_d       = RUN;
            cnt_d         = frame_len;
            pole_enable_d = 1'b1;
            err_d         = 1'b0;
          end
        end
        RUN: begin
          issued_d   = 1'b1;
          pole_din_d = s.s_valid ? s.s_data : '0;
          if (!s.s_valid) err_d = 1'b1;
          if (cnt_q == LEN_W'(1)) begin
            state_d = FLUSH;
            cnt_d   = LEN_W'(TAIL);
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
        FLUSH: begin
          issued_d   = 1'b1;
          pole_din_d = '0;
          if (cnt_q == LEN_W'(1)) begin
            state_d     = DRAIN;
            cnt_d       = '0;
            last_slot_d = 1'b1;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
        DRAIN: begin
          state_d       = IDLE;
          done_d        = 1'b1;
          pole_enable_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      pole_enable_q <= 1'b0;
      pole_din_q    <= '0;
      issued_q      <= 1'b0;
      last_slot_q   <= 1'b0;
      y_data_q      <= '0;
      y_valid_q     <= 1'b0;
      y_last_q      <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pole_enable_q <= pole_enable_d;
      pole_din_q    <= pole_din_d;
      issued_q      <= issued_d;
      last_slot_q   <= last_slot_d;
      y_data_q      <= y_data_d;
      y_valid_q     <= y_valid_d;
      y_last_q      <= y_last_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign s.s_ready    = (state_q == RUN);
  assign busy         = (state_q != IDLE);
  assign pole_enable  = pole_enable_q;
  assign pole_din     = pole_din_q;
  assign s.y_data     = y_data_q;
  assign s.y_valid    = y_valid_q;
  assign s.y_last     = y_last_q;
  assign done         = done_q;
  assign err_underrun = err_q;

endmodule

// File: tb/tb_iir_pole_ctrl.sv
// Scoreboard bench for iir_pole_ctrl with a stand-in pole (x[n], x[n-2], x[n-4] mix).
module tb_iir_pole_ctrl;
  localparam int unsigned STAGE = 8;
  localparam int unsigned WL    = 16;
  localparam int unsigned WL_Y  = 36;
  localparam int unsigned LEN_W = 16;
  localparam int unsigned TAIL  = 4;

  typedef struct { logic [WL_Y-1:0] d; bit last; } exp_t;

  logic clk, nrst, start, abort;
  logic [LEN_W-1:0] frame_len;
  logic pole_enable, busy, done, err_underrun;
  logic [WL-1:0] pole_din;
  logic [WL_Y-1:0] pole_dout;

  iir_pole_ctrl_if #(.WL(WL), .WL_Y(WL_Y)) bus ();

  iir_pole_ctrl #(.STAGE(STAGE), .WL(WL), .WL_Y(WL_Y), .LEN_W(LEN_W), .TAIL(TAIL)) dut (
    .clk(clk), .nrst(nrst), .start(start), .frame_len(frame_len), .abort(abort),
    .s(bus), .pole_enable(pole_enable), .pole_din(pole_din), .pole_dout(pole_dout),
    .busy(busy), .done(done), .err_underrun(err_underrun));

  int total = 0;
  int bad = 0;
  int out_cnt = 0;
  int done_cnt = 0;
  int en_cycles = 0;
  exp_t exp_q[$];
  logic [WL-1:0] xs[$];
  int frame_out0, frame_en0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WL_Y-1:0] mix(input logic [WL-1:0] a, input logic [WL-1:0] b,
                                          input logic [WL-1:0] c);
    mix = WL_Y'(a) ^ (WL_Y'(b) << 5) ^ (WL_Y'(c) << 13) ^ 36'h9_A5C3_0001;
  endfunction

  // Stand-in pole: delay line shifts while enabled, clears while disabled.
  logic [WL-1:0] d1 = '0, d2 = '0, d3 = '0, d4 = '0;
  always @(posedge clk) begin
    if (!pole_enable) begin
      d1 <= '0; d2 <= '0; d3 <= '0; d4 <= '0;
    end else begin
      d1 <= pole_din; d2 <= d1; d3 <= d2; d4 <= d3;
    end
  end
  assign pole_dout = mix(pole_din, d2, d4);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: output k of a frame is mix(x[k], x[k-2], x[k-4]), zeros before the frame.
  function automatic exp_t model(input int k, input bit last);
    exp_t e;
    logic [WL-1:0] b, c;
    b = (k >= 2) ? xs[k-2] : '0;
    c = (k >= 4) ? xs[k-4] : '0;
    e.d = mix(xs[k], b, c);
    e.last = last;
    return e;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT strobes an output.
  always @(negedge clk) begin
    exp_t e;
    if (pole_enable) en_cycles++;
    if (done) done_cnt++;
    if (bus.y_valid) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_y: got y_data=%0h with no expected entry at %0t", bus.y_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("y_data", 64'(bus.y_data), 64'(e.d));
        chk("y_last", 64'(bus.y_last), 64'(e.last));
        chk("done_with_last", 64'(done), 64'(e.last));
      end
    end else if (done || bus.y_last) begin
      total++; bad++;
      $display("FAIL stray_flag: got done=%0b y_last=%0b without y_valid, required 0", done, bus.y_last);
    end
  end

  task automatic do_start(input int unsigned len);
    frame_out0 = out_cnt;
    frame_en0  = en_cycles;
    xs.delete();
    @(negedge clk);
    start = 1'b1; frame_len = LEN_W'(len);
    @(posedge clk); #1;
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_enable", 64'(pole_enable), 64'd1);
    chk("start_err_clear", 64'(err_underrun), 64'd0);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int unsigned len, input int unsigned vpct, input bit inject,
                      output bit any_bad);
    logic v;
    logic [WL-1:0] dat, x;
    any_bad = 1'b0;
    for (int k = 0; k < int'(len); k++) begin
      v   = ($urandom_range(99) < vpct);
      dat = WL'($urandom);
      bus.s_valid = v;
      bus.s_data  = dat;
      x = v ? dat : '0;
      if (!v) any_bad = 1'b1;
      xs.push_back(x);
      exp_q.push_back(model(k, 1'b0));
      chk("s_ready_run", 64'(bus.s_ready), 64'd1);
      if (inject && k == 1) begin start = 1'b1; frame_len = LEN_W'(3); end
      @(posedge clk); #1;
      start = 1'b0;
      chk("slot_din", 64'(pole_din), 64'(x));
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
  endtask

  task automatic finish_frame(input int unsigned len, input bit any_bad);
    bit got;
    for (int unsigned t = 0; t < TAIL; t++) begin
      xs.push_back('0);
      exp_q.push_back(model(int'(len + t), t == TAIL - 1));
    end
    got = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(posedge clk); #1;
      chk("tail_din", 64'(pole_din), 64'd0);
      if (done) begin got = 1'b1; break; end
    end
    chk("done_seen", 64'(got), 64'd1);
    @(negedge clk); #1;
    chk("out_count", 64'(out_cnt - frame_out0), 64'(len + TAIL));
    chk("enable_cycles", 64'(en_cycles - frame_en0), 64'(len + TAIL + 1));
    chk("err_underrun", 64'(err_underrun), 64'(any_bad));
    chk("idle_busy", 64'(busy), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_frame(input int unsigned len, input int unsigned vpct, input bit inject);
    bit ab;
    do_start(len);
    feed(len, vpct, inject, ab);
    finish_frame(len, ab);
  endtask

  initial begin
    #300us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int d0;
    bit ab;
    nrst = 1'b1; start = 1'b0; abort = 1'b0; frame_len = '0;
    bus.s_valid = 1'b0; bus.s_data = '0;
    #2 nrst = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_enable", 64'(pole_enable), 64'd0);
    chk("rst_din", 64'(pole_din), 64'd0);
    chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
    chk("rst_y_valid", 64'(bus.y_valid), 64'd0);
    chk("rst_y_data", 64'(bus.y_data), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err_underrun), 64'd0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic 3-sample frame, no underrun.
    run_frame(3, 100, 1'b0);

    // Underrun on the 2nd slot of a 4-sample frame.
    do_start(4);
    for (int k = 0; k < 4; k++) begin
      logic [WL-1:0] x;
      bus.s_valid = (k != 1);
      bus.s_data  = WL'($urandom);
      x = bus.s_valid ? bus.s_data : '0;
      xs.push_back(x);
      exp_q.push_back(model(k, 1'b0));
      @(posedge clk); #1;
      chk("underrun_din", 64'(pole_din), 64'(x));
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    finish_frame(4, 1'b1);

    // Abort in the 2nd RUN cycle of a 10-sample frame; err is retained.
    do_start(10);
    bus.s_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_pre_err", 64'(err_underrun), 64'd1);
    @(negedge clk);
    d0 = done_cnt;
    abort = 1'b1; bus.s_valid = 1'b1; bus.s_data = WL'($urandom);
    @(posedge clk); #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_enable", 64'(pole_enable), 64'd0);
    chk("abort_din", 64'(pole_din), 64'd0);
    chk("abort_y_valid", 64'(bus.y_valid), 64'd0);
    chk("abort_err_kept", 64'(err_underrun), 64'd1);
    @(negedge clk);
    abort = 1'b0; bus.s_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    run_frame(10, 100, 1'b0);

    // Start while busy and start with frame_len=0 are ignored.
    run_frame(6, 100, 1'b1);
    @(negedge clk);
    start = 1'b1; frame_len = '0;
    @(negedge clk);
    start = 1'b0;
    chk("len0_busy", 64'(busy), 64'd0);
    chk("len0_enable", 64'(pole_enable), 64'd0);

    // Start together with abort in IDLE.
    start = 1'b1; abort = 1'b1; frame_len = LEN_W'(5);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 64'(busy), 64'd0);
    chk("start_abort_enable", 64'(pole_enable), 64'd0);
    repeat (3) @(negedge clk);

    // Randomized frames.
    for (int i = 0; i < 6; i++) begin
      int unsigned len;
      len = $urandom_range(12, 1);
      run_frame(len, 70, (len >= 4) && (i % 2 == 1));
    end

    // Asynchronous reset during FLUSH, then a 1-sample frame.
    d0 = done_cnt;
    do_start(2);
    feed(2, 100, 1'b0, ab);
    #2 nrst = 1'b0;
    #1;
    exp_q.delete();
    chk("frst_busy", 64'(busy), 64'd0);
    chk("frst_enable", 64'(pole_enable), 64'd0);
    chk("frst_din", 64'(pole_din), 64'd0);
    chk("frst_y_valid", 64'(bus.y_valid), 64'd0);
    chk("frst_y_last", 64'(bus.y_last), 64'd0);
    chk("frst_y_data", 64'(bus.y_data), 64'd0);
    chk("frst_done", 64'(done), 64'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk("frst_no_done", 64'(done_cnt - d0), 64'd0);
    run_frame(1, 100, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
